hzrd: RTL and testbench

- Hazard detection unit for the 5-stage RV32I pipeline. Producer end of the forwarding-select interface consumed by the ALU operand forwarding mux.
- Keeps a shadow scoreboard of destination registers in the EX and MEM stages.
- Each cycle it compares the ID-stage instruction's sources against that scoreboard and drives per-operand forward selects, load-use stall, bubble insertion and branch-redirect squash.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/hzrd_match.sv | 37 +++
 rtl/hzrd.sv | 140 ++++++++++++++
 tb/tb_hzrd.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline definitions for the hazard unit.
//   REG_AW     register-index width (32 architectural registers)
//   hz_stage_t per-stage shadow record: valid, destination rd, writes-rd, is-load
//   HZ_BUBBLE  shadow record of an empty (NOP) stage
package pipe_pkg;

    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              load;
    } hz_stage_t;

    localparam hz_stage_t HZ_BUBBLE = '0;

endpackage

// File: rtl/hzrd_match.sv
// hzrd_match: per-operand dependency check of one ID source register against
// the EX and MEM shadow records.
//   src, use_src, id_valid : ID source index, operand-used flag, ID occupancy
//   ex, mem                : shadow records of the EX and MEM stages
//   frwd_alu               : take operand from the EX ALU result
//   frwd_mem_alu           : take operand from the MEM-stage ALU result
//   frwd_mem               : take operand from memory read data
//   load_use               : producer is a load still in EX (cannot forward)
module hzrd_match import pipe_pkg::*; (
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  logic              id_valid,
    input  hz_stage_t         ex,
    input  hz_stage_t         mem,
    output logic              frwd_alu,
    output logic              frwd_mem_alu,
    output logic              frwd_mem,
    output logic              load_use
);

    logic src_live;
    logic ex_hit;
    logic mem_hit;

    // x0 is hard-wired zero, so a write to it is never a real dependency.
    assign src_live = id_valid & use_src & (src != '0);
    assign ex_hit   = src_live & ex.valid  & ex.wen  & (ex.rd  == src);
    assign mem_hit  = src_live & mem.valid & mem.wen & (mem.rd == src);

    // The younger producer (EX) shadows MEM; an EX load hit blocks MEM
    // forwarding too, since MEM would hold a stale value.
    assign frwd_alu     = ex_hit & ~ex.load;
    assign load_use     = ex_hit &  ex.load;
    assign frwd_mem     = ~ex_hit & mem_hit &  mem.load;
    assign frwd_mem_alu = ~ex_hit & mem_hit & ~mem.load;

endmodule

// File: rtl/hzrd.sv
// hzrd: hazard detection unit for the 5-stage RV32I pipeline.
// Tracks EX/MEM destination registers in a shadow scoreboard and, for the
// instruction in ID, drives operand forward selects, load-use stall/bubble
// and redirect flush.
//   i_clk, i_rst              clock, async active-high reset
//   i_id_*                    ID-stage instruction decode info
//   i_redirect                taken branch/jump resolved in EX
//   i_mem_busy                data memory not ready (global freeze)
//   o_frwd_*_op1/op2          per-operand forward selects (one-hot or zero)
//   o_stall / o_bubble        hold PC+IF/ID / insert NOP into ID/EX
//   o_flush                   invalidate IF/ID (wrong-path instruction)
// LOAD_USE_CYC is the number of load-use stall cycles, legal range 1..3.
// REG_AW must match pipe_pkg::REG_AW (the shadow record width).
module hzrd #(
    parameter int REG_AW       = 5,
    parameter int LOAD_USE_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_wen,
    input  logic              i_id_load,
    input  logic              i_redirect,
    input  logic              i_mem_busy,
    output logic              o_frwd_alu_op1,
    output logic              o_frwd_mem_alu_op1,
    output logic              o_frwd_mem_op1,
    output logic              o_frwd_alu_op2,
    output logic              o_frwd_mem_alu_op2,
    output logic              o_frwd_mem_op2,
    output logic              o_stall,
    output logic              o_bubble,
    output logic              o_flush
);

    localparam int               LUC_W    = $clog2(LOAD_USE_CYC + 1);
    localparam logic [LUC_W-1:0] LUC_INIT = LUC_W'(LOAD_USE_CYC - 1);

    pipe_pkg::hz_stage_t ex_q;
    pipe_pkg::hz_stage_t mem_q;
    pipe_pkg::hz_stage_t id_info;
    logic [LUC_W-1:0]    luc_q;
    logic                live_q;   // low in reset and the first cycle after release

    logic f1_alu, f1_mem_alu, f1_mem, lu1;
    logic f2_alu, f2_mem_alu, f2_mem, lu2;
    logic lu_raw, luc_busy, hold_c;
    logic stall_c, bubble_c, flush_c;

    assign id_info = '{valid: 1'b1, rd: i_id_rd, wen: i_id_wen, load: i_id_load};

    hzrd_match u_match_rs1 (
        .src          (i_id_rs1),
        .use_src      (i_id_use_rs1),
        .id_valid     (i_id_valid),
        .ex           (ex_q),
        .mem          (mem_q),
        .frwd_alu     (f1_alu),
        .frwd_mem_alu (f1_mem_alu),
        .frwd_mem     (f1_mem),
        .load_use     (lu1)
    );

    hzrd_match u_match_rs2 (
        .src          (i_id_rs2),
        .use_src      (i_id_use_rs2),
        .id_valid     (i_id_valid),
        .ex           (ex_q),
        .mem          (mem_q),
        .frwd_alu     (f2_alu),
        .frwd_mem_alu (f2_mem_alu),
        .frwd_mem     (f2_mem),
        .load_use     (lu2)
    );

    assign lu_raw   = lu1 | lu2;
    assign luc_busy = (luc_q != '0);
    assign hold_c   = lu_raw | luc_busy;

    // Freeze beats redirect; redirect beats a load-use hold so the PC can
    // take the branch target.
    always_comb begin
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        if (i_mem_busy) begin
            stall_c = 1'b1;
        end else if (i_redirect) begin
            bubble_c = 1'b1;
            flush_c  = 1'b1;
        end else begin
            stall_c  = hold_c;
            bubble_c = hold_c;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ex_q   <= pipe_pkg::HZ_BUBBLE;
            mem_q  <= pipe_pkg::HZ_BUBBLE;
            luc_q  <= '0;
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (!i_mem_busy) begin
                mem_q <= ex_q;
                if (bubble_c || !i_id_valid) begin
                    ex_q <= pipe_pkg::HZ_BUBBLE;
                end else begin
                    ex_q <= id_info;
                end
                if (i_redirect) begin
                    luc_q <= '0;
                end else if (luc_busy) begin
                    luc_q <= luc_q - LUC_W'(1);
                end else if (lu_raw) begin
                    luc_q <= LUC_INIT;
                end
            end
        end
    end

    // Extra load-use cycles leave the load in WB; the register file then
    // supplies the operand, so forwarding is suppressed while counting.
    assign o_frwd_alu_op1     = live_q & ~luc_busy & f1_alu;
    assign o_frwd_mem_alu_op1 = live_q & ~luc_busy & f1_mem_alu;
    assign o_frwd_mem_op1     = live_q & ~luc_busy & f1_mem;
    assign o_frwd_alu_op2     = live_q & ~luc_busy & f2_alu;
    assign o_frwd_mem_alu_op2 = live_q & ~luc_busy & f2_mem_alu;
    assign o_frwd_mem_op2     = live_q & ~luc_busy & f2_mem;
    assign o_stall            = live_q & stall_c;
    assign o_bubble           = live_q & bubble_c;
    assign o_flush            = live_q & flush_c;

endmodule

// File: tb/tb_hzrd.sv
module tb_hzrd;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       id_wen = 1'b0, id_load = 1'b0;
    logic       redirect = 1'b0, mem_busy = 1'b0;

    logic a_alu1, a_malu1, a_mem1, a_alu2, a_malu2, a_mem2, a_stall, a_bubble, a_flush;
    logic b_alu1, b_malu1, b_mem1, b_alu2, b_malu2, b_mem2, b_stall, b_bubble, b_flush;
    logic [8:0] got_a, got_b;

    assign got_a = {a_alu1, a_malu1, a_mem1, a_alu2, a_malu2, a_mem2, a_stall, a_bubble, a_flush};
    assign got_b = {b_alu1, b_malu1, b_mem1, b_alu2, b_malu2, b_mem2, b_stall, b_bubble, b_flush};

    hzrd #(.REG_AW(5), .LOAD_USE_CYC(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_id_rd(id_rd), .i_id_wen(id_wen), .i_id_load(id_load),
        .i_redirect(redirect), .i_mem_busy(mem_busy),
        .o_frwd_alu_op1(a_alu1), .o_frwd_mem_alu_op1(a_malu1), .o_frwd_mem_op1(a_mem1),
        .o_frwd_alu_op2(a_alu2), .o_frwd_mem_alu_op2(a_malu2), .o_frwd_mem_op2(a_mem2),
        .o_stall(a_stall), .o_bubble(a_bubble), .o_flush(a_flush)
    );

    hzrd #(.REG_AW(5), .LOAD_USE_CYC(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_id_rd(id_rd), .i_id_wen(id_wen), .i_id_load(id_load),
        .i_redirect(redirect), .i_mem_busy(mem_busy),
        .o_frwd_alu_op1(b_alu1), .o_frwd_mem_alu_op1(b_malu1), .o_frwd_mem_op1(b_mem1),
        .o_frwd_alu_op2(b_alu2), .o_frwd_mem_alu_op2(b_malu2), .o_frwd_mem_op2(b_mem2),
        .o_stall(b_stall), .o_bubble(b_bubble), .o_flush(b_flush)
    );

    // ---------------- reference model ----------------
    // In-flight instructions, youngest first: slot 0 = EX, slot 1 = MEM.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       w;
        bit       ld;
    } rec_t;

    rec_t flight [2][2];
    int   wait_left [2];   // remaining extra stall cycles of a load-use
    bit   live [2];
    int   cyc_cfg [2] = '{1, 2};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    localparam int P_NONE = 0, P_EX_ALU = 1, P_EX_LOAD = 2, P_MEM_ALU = 3, P_MEM_LOAD = 4;

    // Which in-flight producer supplies this source (youngest writer wins).
    function automatic int producer(int k, logic [4:0] src, logic use_it);
        if (!id_valid || !use_it || src == 5'd0) return P_NONE;
        for (int age = 0; age < 2; age++) begin
            if (flight[k][age].v && flight[k][age].w && flight[k][age].rd == src) begin
                if (age == 0) return flight[k][age].ld ? P_EX_LOAD : P_EX_ALU;
                return flight[k][age].ld ? P_MEM_LOAD : P_MEM_ALU;
            end
        end
        return P_NONE;
    endfunction

    function automatic logic [2:0] sel_bits(int p, bit waiting);
        if (waiting) return 3'b000;
        return {p == P_EX_ALU, p == P_MEM_ALU, p == P_MEM_LOAD};
    endfunction

    function automatic logic [8:0] expected(int k);
        int p1, p2;
        bit waiting, hold;
        logic [8:0] e;
        if (!live[k]) return 9'd0;
        p1 = producer(k, id_rs1, id_use_rs1);
        p2 = producer(k, id_rs2, id_use_rs2);
        waiting = wait_left[k] > 0;
        hold = (p1 == P_EX_LOAD) || (p2 == P_EX_LOAD) || waiting;
        e[8:6] = sel_bits(p1, waiting);
        e[5:3] = sel_bits(p2, waiting);
        if (mem_busy)      e[2:0] = 3'b100;
        else if (redirect) e[2:0] = 3'b011;
        else               e[2:0] = {hold, hold, 1'b0};
        return e;
    endfunction

    function automatic void model_clear(int k);
        flight[k][0] = '{v: 0, rd: 0, w: 0, ld: 0};
        flight[k][1] = '{v: 0, rd: 0, w: 0, ld: 0};
        wait_left[k] = 0;
        live[k] = 0;
    endfunction

    function automatic void model_clock(int k);
        bit lu, waiting, squash;
        lu = (producer(k, id_rs1, id_use_rs1) == P_EX_LOAD) ||
             (producer(k, id_rs2, id_use_rs2) == P_EX_LOAD);
        waiting = wait_left[k] > 0;
        live[k] = 1;
        if (mem_busy) return;
        squash = redirect || !id_valid || lu || waiting;
        flight[k][1] = flight[k][0];
        if (squash) flight[k][0] = '{v: 0, rd: 0, w: 0, ld: 0};
        else        flight[k][0] = '{v: 1, rd: id_rd, w: id_wen, ld: id_load};
        if (redirect)     wait_left[k] = 0;
        else if (waiting) wait_left[k] = wait_left[k] - 1;
        else if (lu)      wait_left[k] = cyc_cfg[k] - 1;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_now(string tag);
        logic [8:0] g, e;
        for (int k = 0; k < 2; k++) begin
            g = (k == 0) ? got_a : got_b;
            e = expected(k);
            n_checks++;
            assert (g === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s cyc%0d got=%b exp=%b", tag, cyc_cfg[k], g, e);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1: sample at negedge, advance model at posedge.
    task automatic do_cycle(string tag);
        @(negedge clk);
        check_now(tag);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) model_clear(k);
            else     model_clock(k);
        end
        #1;
    endtask

    task automatic set_rst(bit v);
        rst = v;
        if (v) begin
            model_clear(0);
            model_clear(1);
        end
    endtask

    task automatic set_ctl(bit rd_ir, bit busy);
        redirect = rd_ir;
        mem_busy = busy;
    endtask

    task automatic set_id(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit w, bit ld);
        id_valid   = v;
        id_rs1     = 5'(rs1);
        id_rs2     = 5'(rs2);
        id_use_rs1 = u1;
        id_use_rs2 = u2;
        id_rd      = 5'(rd);
        id_wen     = w;
        id_load    = ld;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_rst(1);
        nop();
        set_ctl(0, 0);
        #1;
        do_cycle("in_reset_0");
        set_ctl(1, 1);
        do_cycle("in_reset_1");
        set_rst(0);
        do_cycle("first_after_release");
        set_ctl(0, 0);

        // EX ALU forward to op1
        set_id(1, 1, 2, 1, 1, 5, 1, 0); do_cycle("add_x5");
        set_id(1, 5, 7, 1, 1, 6, 1, 0); do_cycle("ex_alu_op1");

        // MEM ALU forward to op2, then same with rs2 unused
        set_id(1, 1, 2, 1, 1, 5, 1, 0); do_cycle("add_x5_b");
        nop();                          do_cycle("gap_b");
        set_id(1, 1, 5, 1, 1, 8, 1, 0); do_cycle("mem_alu_op2");
        set_id(1, 1, 2, 1, 1, 5, 1, 0); do_cycle("add_x5_c");
        nop();                          do_cycle("gap_c");
        set_id(1, 1, 5, 1, 0, 8, 1, 0); do_cycle("addi_no_rs2");

        // Load-use with both operands on the load result
        set_id(1, 1, 2, 1, 1, 9, 1, 1);  do_cycle("lw_x9");
        set_id(1, 9, 9, 1, 1, 10, 1, 0); do_cycle("lu_stall_1");
        do_cycle("lu_stall_2");
        do_cycle("lu_stall_3");
        nop();                           do_cycle("lu_drain");

        // x5 in both EX and MEM: EX wins
        set_id(1, 1, 2, 1, 1, 5, 1, 0); do_cycle("add_x5_old");
        set_id(1, 3, 4, 1, 1, 5, 1, 0); do_cycle("add_x5_new");
        set_id(1, 5, 3, 1, 1, 6, 1, 0); do_cycle("ex_over_mem");

        // x0 writers never match
        set_id(1, 1, 2, 1, 1, 0, 1, 0); do_cycle("add_x0");
        set_id(1, 0, 0, 1, 1, 6, 1, 0); do_cycle("read_x0");
        set_id(1, 1, 2, 1, 1, 0, 1, 1); do_cycle("lw_x0");
        set_id(1, 0, 0, 1, 1, 6, 1, 0); do_cycle("lw_x0_nostall");

        // Load-use concurrent with redirect
        set_id(1, 1, 2, 1, 1, 9, 1, 1);  do_cycle("lw_x9_r");
        set_id(1, 9, 2, 1, 1, 10, 1, 0); set_ctl(1, 0); do_cycle("lu_redirect");
        set_ctl(0, 0);
        set_id(1, 9, 2, 1, 1, 11, 1, 0); do_cycle("after_redirect");
        nop();                           do_cycle("after_redirect_2");

        // Freeze for 3 cycles with an EX dependency pending
        set_id(1, 1, 2, 1, 1, 5, 1, 0); do_cycle("add_x5_f");
        set_id(1, 5, 1, 1, 1, 6, 1, 0); set_ctl(0, 1);
        do_cycle("busy_1");
        do_cycle("busy_2");
        set_ctl(1, 1); do_cycle("busy_redirect");
        set_ctl(0, 0); do_cycle("busy_release");

        // Async reset in the middle of a load-use stall
        set_id(1, 1, 2, 1, 1, 9, 1, 1);  do_cycle("lw_x9_rst");
        set_id(1, 9, 9, 1, 1, 10, 1, 0);
        #2;
        set_rst(1);
        #1;
        check_now("async_rst");
        do_cycle("rst_held");
        set_rst(0);
        do_cycle("rst_release");
        do_cycle("no_residual");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (rst) set_rst(0);
            else if ($urandom_range(0, 79) == 0) set_rst(1);
            set_id($urandom_range(0, 7) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0);
            set_ctl($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            do_cycle("random");
        end

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
